// File: rtl/seqgen_pkg.sv
// seqgen_pkg: shared types and default framing constants for the serial
// frame generator (seqgen) and the sequence detector bench.
package seqgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } seq_state_e;

  localparam int         SEQGEN_SYNC_LEN = 5;
  localparam logic [4:0] SEQGEN_SYNC_PAT = 5'b10010;
  localparam int         SEQGEN_DATA_W   = 8;
  localparam int         SEQGEN_GAP_LEN  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// seq_piso: loadable MSB-first parallel-in serial-out register.
// The serial output is the register MSB itself, so it is a flop output.
module seq_piso #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_pdata,
  input  logic         i_sin,
  output logic         o_sout
);

  logic [W-1:0] r_sr;

  // load has priority over shift; shift moves toward the MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_sr <= '0;
    else if (i_load)  r_sr <= i_pdata;
    else if (i_shift) r_sr <= {r_sr[W-2:0], i_sin};
  end

  assign o_sout = r_sr[W-1];

endmodule

// File: rtl/seqgen.sv
// seqgen: serial frame generator. Frame = sync pattern, data MSB first,
// optional even-parity bit, then GAP_LEN idle zeros.
// Optional feature: define SEQGEN_PARITY_EN to append the parity bit.
//
// Sync and data are loaded together into one PISO at acceptance and
// shifted out with zero fill, so the line naturally returns to 0 once the
// payload is gone. With parity, the parity bit is injected on the first
// shift so it arrives at the MSB exactly one cycle after the data LSB.
module seqgen
  import seqgen_pkg::*;
#(
  parameter int                  SYNC_LEN = SEQGEN_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_LEN'(SEQGEN_SYNC_PAT),
  parameter int                  DATA_W   = SEQGEN_DATA_W,
  parameter int                  GAP_LEN  = SEQGEN_GAP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              x_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRM_W = SYNC_LEN + DATA_W;
  localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_LEN) + 1);
  localparam seq_state_e GAP_OR_IDLE = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;

  seq_state_e       r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_x_en, r_busy, r_frame_done;
  logic             w_accept, w_last, w_shift, w_sin;

  assign din_ready = (r_state == ST_IDLE);
  assign w_accept  = din_valid & din_ready;
  assign w_shift   = (r_state == ST_SYNC) || (r_state == ST_DATA) || (r_state == ST_PAR);

`ifdef SEQGEN_PARITY_EN
  logic r_par;

  // even parity of the word, captured alongside it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_par <= 1'b0;
    else if (w_accept) r_par <= ^din;
  end

  assign w_sin = (r_state == ST_SYNC && r_cnt == '0) ? r_par : 1'b0;
`else
  assign w_sin = 1'b0;
`endif

  // last cycle of the current timed phase
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_SYNC: w_last = (32'(r_cnt) == 32'(SYNC_LEN - 1));
      ST_DATA: w_last = (32'(r_cnt) == 32'(DATA_W - 1));
      ST_GAP:  w_last = (32'(r_cnt) == 32'(GAP_LEN - 1));
      default: w_last = 1'b0;
    endcase
  end

  // next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nxt = ST_SYNC;
      ST_SYNC: if (w_last)   w_nxt = ST_DATA;
`ifdef SEQGEN_PARITY_EN
      ST_DATA: if (w_last)   w_nxt = ST_PAR;
`else
      ST_DATA: if (w_last)   w_nxt = GAP_OR_IDLE;
`endif
      ST_PAR:                w_nxt = GAP_OR_IDLE;
      ST_GAP:  if (w_last)   w_nxt = ST_IDLE;
      default:               w_nxt = ST_IDLE;
    endcase
  end

  // state, phase counter and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_x_en       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      if (w_nxt != r_state)      r_cnt <= '0;
      else if (r_state != ST_IDLE) r_cnt <= r_cnt + CNT_W'(1);
      r_x_en       <= (w_nxt == ST_SYNC) || (w_nxt == ST_DATA) || (w_nxt == ST_PAR);
      r_busy       <= (w_nxt != ST_IDLE);
      r_frame_done <= (r_state != ST_IDLE) && (w_nxt == ST_IDLE);
    end
  end

  seq_piso #(.W(FRM_W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_pdata ({SYNC_PAT, din}),
    .i_sin   (w_sin),
    .o_sout  (x)
  );

  assign x_en       = r_x_en;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seqgen.sv
// tb_seqgen: directed bench for seqgen with default parameters.
// Honours SEQGEN_PARITY_EN when the bundle is built with it.
module tb_seqgen;

`ifdef SEQGEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = 13 + PB;   // sync + data (+ parity)
  localparam int G = 2;         // gap bits

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, x, x_en, busy, frame_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seqgen dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .x          (x),
    .x_en       (x_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // expected bit i of a frame carrying d
  function automatic logic fbit(input logic [7:0] d, input int i);
    logic [4:0] s;
    s = 5'b10010;
    if (i < 5)  return s[4-i];
    if (i < 13) return d[12-i];
    return ^d;
  endfunction

  // entered in cycle k+1 after acceptance at edge k; returns in the
  // frame_done cycle with the serial bits collected in bits
  task automatic run_frame(input logic [7:0] d, input string nm, output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < L; i++) begin
      bits = {bits[14:0], x};
      chk($sformatf("%s_x%0d", nm, i), {31'd0, x}, {31'd0, fbit(d, i)});
      chk($sformatf("%s_en%0d", nm, i), {31'd0, x_en}, 32'd1);
      chk($sformatf("%s_busy%0d", nm, i), {31'd0, busy}, 32'd1);
      step();
    end
    for (int g = 0; g < G; g++) begin
      chk($sformatf("%s_gap%0d", nm, g), {29'd0, x, x_en, busy}, 32'b001);
      step();
    end
    chk($sformatf("%s_done", nm), {29'd0, frame_done, din_ready, busy}, 32'b110);
  endtask

  logic [15:0] got_bits;

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0;

    // reset state, and a valid pulse during reset must be ignored
    repeat (2) step();
    chk("rst_out", {27'd0, x, x_en, busy, frame_done, din_ready}, 32'b00001);
    din_valid = 1'b1; din = 8'h5A;
    repeat (2) step();
    chk("rst_vld", {29'd0, x_en, busy, din_ready}, 32'b001);
    din_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) step();
    chk("post_rst", {29'd0, x_en, busy, din_ready}, 32'b001);

    // single frame A5
    @(negedge clk); din = 8'hA5; din_valid = 1'b1;
    step(); din_valid = 1'b0;
    run_frame(8'hA5, "a5", got_bits);
`ifdef SEQGEN_PARITY_EN
    chk("a5_bits", {16'd0, got_bits}, 32'h254A);
`else
    chk("a5_bits", {16'd0, got_bits}, 32'h12A5);
`endif

    // back-to-back with valid held high: 00, FF, 3C
    din = 8'h00; din_valid = 1'b1;
    step(); din = 8'hFF;
    run_frame(8'h00, "b00", got_bits);
    step(); din = 8'h3C;
    run_frame(8'hFF, "bff", got_bits);
    step(); din_valid = 1'b0;
    run_frame(8'h3C, "b3c", got_bits);

    // reset in the middle of a frame, on a data-1 bit
    din = 8'hFF; din_valid = 1'b1;
    step(); din_valid = 1'b0;
    repeat (6) step();
    chk("mid_x_before", {31'd0, x}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("mid_rst", {27'd0, x, x_en, busy, frame_done, din_ready}, 32'b00001);
    din_valid = 1'b1;
    repeat (2) step();
    din_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("no_resume%0d", i), {29'd0, x, x_en, busy}, 32'b000);
    end

    // clean frame after reset
    @(negedge clk); din = 8'h3C; din_valid = 1'b1;
    step(); din_valid = 1'b0;
    run_frame(8'h3C, "r3c", got_bits);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
